player_life_controller: RTL and testbench

- Per-player life sequencer between collision detection and the top-level game state machine.
- Tracks remaining lives and sequences each death: death animation, respawn with temporary invulnerability and blinking, then out-of-lives.
- Drives the level-sensitive playerDead input of the game state controller.
- Advances on the per-frame vsync tick. All timing is counted in frames, not in Clk cycles.

---
 rtl/player_life_controller.sv | 156 +++++++++++++++
 tb/tb_player_life_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/player_life_controller.sv
// Per-player life sequencer: tracks lives and sequences death, respawn/invulnerability and out-of-lives.
// Optional feature macro: PLAYER_EXTRA_LIFE_EN adds the extra_life award input.
module player_life_controller #(
    parameter int START_LIVES   = 3,
    parameter int LIFE_W        = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_SHIFT   = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [1:0]        gameState,
    input  logic              hit,
    input  logic              fall,
`ifdef PLAYER_EXTRA_LIFE_EN
    input  logic              extra_life,
`endif
    output logic [LIFE_W-1:0] lives,
    output logic              playerDead,
    output logic              player_visible,
    output logic              invulnerable,
    output logic              dying,
    output logic              spawn_pulse
);

    localparam int MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int CW         = $clog2(MAX_FRAMES + 1);

    localparam logic [CW-1:0]     DEATH_LAST  = CW'(DEATH_FRAMES - 1);
    localparam logic [CW-1:0]     INVULN_LAST = CW'(INVULN_FRAMES - 1);
    localparam logic [LIFE_W-1:0] LIVES_START = LIFE_W'(START_LIVES);
    localparam logic [LIFE_W-1:0] LIVES_MAX   = {LIFE_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        ALIVE,
        DYING,
        RESPAWN,
        OUT
    } state_t;

    state_t            state, stateNext;
    logic [CW-1:0]     counter, counterNext;
    logic [LIFE_W-1:0] livesNext;
    logic              death, extra;
    logic              deadNext, visibleNext, invulnNext, dyingNext, spawnNext;

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        livesNext   = lives;
        death       = 1'b0;
`ifdef PLAYER_EXTRA_LIFE_EN
        extra       = extra_life && (state == ALIVE || state == DYING || state == RESPAWN);
`else
        extra       = 1'b0;
`endif

        case (state)
            ALIVE:   death = hit | fall;
            RESPAWN: death = fall;
            default: death = 1'b0;
        endcase

        // A death and an award in the same cycle cancel out
        if (death && !extra) begin
            livesNext = (lives == '0) ? lives : lives - LIFE_W'(1);
        end else if (extra && !death) begin
            livesNext = (lives == LIVES_MAX) ? lives : lives + LIFE_W'(1);
        end

        case (state)
            IDLE: begin
                if (gameState == 2'b01) begin
                    stateNext   = ALIVE;
                    counterNext = '0;
                    livesNext   = LIVES_START;
                end
            end
            ALIVE: begin
                if (death) begin
                    stateNext   = DYING;
                    counterNext = '0;
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (counter == DEATH_LAST) begin
                        stateNext   = (livesNext == '0) ? OUT : RESPAWN;
                        counterNext = '0;
                    end else begin
                        counterNext = counter + CW'(1);
                    end
                end
            end
            RESPAWN: begin
                if (death) begin
                    stateNext   = DYING;
                    counterNext = '0;
                end else if (frame_tick) begin
                    if (counter == INVULN_LAST) begin
                        stateNext   = ALIVE;
                        counterNext = '0;
                    end else begin
                        counterNext = counter + CW'(1);
                    end
                end
            end
            default: begin
                stateNext = state;
            end
        endcase

        // Leaving Play from any state (including OUT on GameOver) parks the block in IDLE
        if (gameState != 2'b01) begin
            stateNext   = IDLE;
            counterNext = '0;
            livesNext   = '0;
        end

        deadNext    = (stateNext == OUT);
        invulnNext  = (stateNext == RESPAWN);
        dyingNext   = (stateNext == DYING);
        spawnNext   = (state == IDLE  && stateNext == ALIVE) ||
                      (state == DYING && stateNext == RESPAWN);
        case (stateNext)
            ALIVE, DYING: visibleNext = 1'b1;
            RESPAWN:      visibleNext = ~counterNext[BLINK_SHIFT];
            default:      visibleNext = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            counter        <= '0;
            lives          <= '0;
            playerDead     <= 1'b0;
            player_visible <= 1'b0;
            invulnerable   <= 1'b0;
            dying          <= 1'b0;
            spawn_pulse    <= 1'b0;
        end else begin
            state          <= stateNext;
            counter        <= counterNext;
            lives          <= livesNext;
            playerDead     <= deadNext;
            player_visible <= visibleNext;
            invulnerable   <= invulnNext;
            dying          <= dyingNext;
            spawn_pulse    <= spawnNext;
        end
    end

endmodule

// File: tb/tb_player_life_controller.sv
// Directed self-checking bench for player_life_controller (DEATH_FRAMES=4, INVULN_FRAMES=8, BLINK_SHIFT=1).
module tb_player_life_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] gameState = 2'b00;
    logic       hit = 1'b0;
    logic       fall = 1'b0;
`ifdef PLAYER_EXTRA_LIFE_EN
    logic       extra_life = 1'b0;
`endif
    logic [2:0] lives;
    logic       playerDead, player_visible, invulnerable, dying, spawn_pulse;

    int total = 0;
    int bad   = 0;

    // Observed outputs packed as {dead, visible, invuln, dying, spawn, lives[2:0]}
    logic [7:0] obs;
    assign obs = {playerDead, player_visible, invulnerable, dying, spawn_pulse, lives};

    player_life_controller #(
        .START_LIVES(3), .LIFE_W(3), .DEATH_FRAMES(4), .INVULN_FRAMES(8), .BLINK_SHIFT(1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .gameState(gameState),
        .hit(hit), .fall(fall),
`ifdef PLAYER_EXTRA_LIFE_EN
        .extra_life(extra_life),
`endif
        .lives(lives), .playerDead(playerDead), .player_visible(player_visible),
        .invulnerable(invulnerable), .dying(dying), .spawn_pulse(spawn_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic waitNeg(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; gameState = 2'b00;
        waitNeg(2);
        total++; if (obs !== 8'b0_0_0_0_0_000) begin bad++; $display("FAIL reset_values: got %b want %b", obs, 8'b0); end
        Reset = 1'b0;
        waitNeg(1);
        total++; if (obs !== 8'b0_0_0_0_0_000) begin bad++; $display("FAIL idle_after_reset: got %b want %b", obs, 8'b0); end
    endtask

    task automatic test_start();
        gameState = 2'b01;
        waitNeg(1);
        total++; if (obs !== 8'b0_1_0_0_1_011) begin bad++; $display("FAIL start_spawn: got %b want %b", obs, 8'b0_1_0_0_1_011); end
        waitNeg(1);
        total++; if (obs !== 8'b0_1_0_0_0_011) begin bad++; $display("FAIL start_alive: got %b want %b", obs, 8'b0_1_0_0_0_011); end
    endtask

    task automatic test_death_cycle();
        logic [6:0] blinkExp;
        logic [7:0] exp;
        blinkExp = 7'b0011001;
        hit = 1'b1; waitNeg(1); hit = 1'b0;
        total++; if (obs !== 8'b0_1_0_1_0_010) begin bad++; $display("FAIL hit_dying: got %b want %b", obs, 8'b0_1_0_1_0_010); end
        repeat (3) tick();
        total++; if (obs !== 8'b0_1_0_1_0_010) begin bad++; $display("FAIL dying_3_ticks: got %b want %b", obs, 8'b0_1_0_1_0_010); end
        tick();
        total++; if (obs !== 8'b0_1_1_0_1_010) begin bad++; $display("FAIL respawn_entry: got %b want %b", obs, 8'b0_1_1_0_1_010); end
        for (int i = 0; i < 7; i++) begin
            tick();
            exp = {1'b0, blinkExp[i], 1'b1, 1'b0, 1'b0, 3'd2};
            total++; if (obs !== exp) begin bad++; $display("FAIL blink_tick%0d: got %b want %b", i + 1, obs, exp); end
        end
        tick();
        total++; if (obs !== 8'b0_1_0_0_0_010) begin bad++; $display("FAIL respawn_to_alive: got %b want %b", obs, 8'b0_1_0_0_0_010); end
    endtask

    task automatic test_respawn_hazards();
        fall = 1'b1; waitNeg(1); fall = 1'b0;
        total++; if (obs !== 8'b0_1_0_1_0_001) begin bad++; $display("FAIL fall_dying: got %b want %b", obs, 8'b0_1_0_1_0_001); end
        repeat (4) tick();
        total++; if (obs !== 8'b0_1_1_0_1_001) begin bad++; $display("FAIL respawn2_entry: got %b want %b", obs, 8'b0_1_1_0_1_001); end
        hit = 1'b1; waitNeg(1); hit = 1'b0;
        total++; if (obs !== 8'b0_1_1_0_0_001) begin bad++; $display("FAIL hit_ignored_respawn: got %b want %b", obs, 8'b0_1_1_0_0_001); end
        fall = 1'b1; waitNeg(1); fall = 1'b0;
        total++; if (obs !== 8'b0_1_0_1_0_000) begin bad++; $display("FAIL fall_in_respawn: got %b want %b", obs, 8'b0_1_0_1_0_000); end
    endtask

    task automatic test_out();
        repeat (3) tick();
        total++; if (obs !== 8'b0_1_0_1_0_000) begin bad++; $display("FAIL last_dying: got %b want %b", obs, 8'b0_1_0_1_0_000); end
        tick();
        total++; if (obs !== 8'b1_0_0_0_0_000) begin bad++; $display("FAIL out_entry: got %b want %b", obs, 8'b1_0_0_0_0_000); end
        hit = 1'b1; fall = 1'b1; waitNeg(3); hit = 1'b0; fall = 1'b0;
        total++; if (obs !== 8'b1_0_0_0_0_000) begin bad++; $display("FAIL out_hold: got %b want %b", obs, 8'b1_0_0_0_0_000); end
        gameState = 2'b10; waitNeg(1);
        total++; if (obs !== 8'b0_0_0_0_0_000) begin bad++; $display("FAIL gameover_release: got %b want %b", obs, 8'b0); end
        gameState = 2'b01; waitNeg(1);
        total++; if (obs !== 8'b0_1_0_0_1_011) begin bad++; $display("FAIL replay_reload: got %b want %b", obs, 8'b0_1_0_0_1_011); end
        waitNeg(1);
    endtask

    task automatic test_simultaneous();
        hit = 1'b1; fall = 1'b1; frame_tick = 1'b1;
        waitNeg(1);
        frame_tick = 1'b0;
        total++; if (obs !== 8'b0_1_0_1_0_010) begin bad++; $display("FAIL hit_fall_single: got %b want %b", obs, 8'b0_1_0_1_0_010); end
        waitNeg(2);
        hit = 1'b0; fall = 1'b0;
        total++; if (obs !== 8'b0_1_0_1_0_010) begin bad++; $display("FAIL dying_ignores_hits: got %b want %b", obs, 8'b0_1_0_1_0_010); end
        repeat (3) tick();
        total++; if (obs !== 8'b0_1_0_1_0_010) begin bad++; $display("FAIL coincident_tick_uncounted: got %b want %b", obs, 8'b0_1_0_1_0_010); end
        gameState = 2'b00; waitNeg(1);
        total++; if (obs !== 8'b0_0_0_0_0_000) begin bad++; $display("FAIL abort_mid_dying: got %b want %b", obs, 8'b0); end
    endtask

    task automatic test_reset_mid();
        gameState = 2'b01; waitNeg(2);
        hit = 1'b1; waitNeg(1); hit = 1'b0;
        repeat (6) tick();
        total++; if (obs !== 8'b0_0_1_0_0_010) begin bad++; $display("FAIL respawn_blink_off: got %b want %b", obs, 8'b0_0_1_0_0_010); end
        Reset = 1'b1; waitNeg(1);
        total++; if (obs !== 8'b0_0_0_0_0_000) begin bad++; $display("FAIL reset_mid_respawn: got %b want %b", obs, 8'b0); end
        waitNeg(1);
        total++; if (obs !== 8'b0_0_0_0_0_000) begin bad++; $display("FAIL reset_held: got %b want %b", obs, 8'b0); end
        Reset = 1'b0; waitNeg(1);
        total++; if (obs !== 8'b0_1_0_0_1_011) begin bad++; $display("FAIL restart_after_reset: got %b want %b", obs, 8'b0_1_0_0_1_011); end
        waitNeg(1);
    endtask

`ifdef PLAYER_EXTRA_LIFE_EN
    task automatic test_extra_life();
        hit = 1'b1; waitNeg(1); hit = 1'b0;
        repeat (4) tick();
        fall = 1'b1; waitNeg(1); fall = 1'b0;
        repeat (4) tick();
        fall = 1'b1; waitNeg(1); fall = 1'b0;
        total++; if (obs !== 8'b0_1_0_1_0_000) begin bad++; $display("FAIL extra_setup: got %b want %b", obs, 8'b0_1_0_1_0_000); end
        extra_life = 1'b1; waitNeg(1); extra_life = 1'b0;
        total++; if (obs !== 8'b0_1_0_1_0_001) begin bad++; $display("FAIL extra_in_dying: got %b want %b", obs, 8'b0_1_0_1_0_001); end
        repeat (4) tick();
        total++; if (obs !== 8'b0_1_1_0_1_001) begin bad++; $display("FAIL extra_saves_respawn: got %b want %b", obs, 8'b0_1_1_0_1_001); end
        extra_life = 1'b1; waitNeg(6); extra_life = 1'b0;
        total++; if (obs !== 8'b0_1_1_0_0_111) begin bad++; $display("FAIL extra_to_max: got %b want %b", obs, 8'b0_1_1_0_0_111); end
        extra_life = 1'b1; waitNeg(2); extra_life = 1'b0;
        total++; if (obs !== 8'b0_1_1_0_0_111) begin bad++; $display("FAIL extra_saturate: got %b want %b", obs, 8'b0_1_1_0_0_111); end
        fall = 1'b1; extra_life = 1'b1; waitNeg(1); fall = 1'b0; extra_life = 1'b0;
        total++; if (obs !== 8'b0_1_0_1_0_111) begin bad++; $display("FAIL extra_with_death: got %b want %b", obs, 8'b0_1_0_1_0_111); end
    endtask
`endif

    initial begin
        @(negedge Clk);
        test_reset();
        test_start();
        test_death_cycle();
        test_respawn_hazards();
        test_out();
        test_simultaneous();
        test_reset_mid();
`ifdef PLAYER_EXTRA_LIFE_EN
        test_extra_life();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
